// File: rtl/reset_sequencer_pf_if.sv
// Sequencer-to-fabric bundle: per-domain ready acks in, domain resets and status out.
// Latency: none (wiring only).
// Backpressure: none; every signal is a level.
//
// Ports (from the sequencer's side, modport master):
//   DOMAIN_READY    in   per-domain ready ack, level, any clock domain
//   DOMAIN_RESET_N  out  per-domain reset, active-low
//   SEQ_DONE        out  all domains released and acknowledged
//   SEQ_FAULT       out  ack timeout with retries exhausted (sticky)
//   FAULT_IDX       out  index of the domain that last timed out
//   RETRY_CNT       out  retries consumed since the last reset
interface reset_sequencer_pf_if #(
  parameter int NUM_DOMAINS = 4
);
  logic [NUM_DOMAINS-1:0] DOMAIN_READY;
  logic [NUM_DOMAINS-1:0] DOMAIN_RESET_N;
  logic                   SEQ_DONE;
  logic                   SEQ_FAULT;
  logic [2:0]             FAULT_IDX;
  logic [2:0]             RETRY_CNT;

  modport master (
    input  DOMAIN_READY,
    output DOMAIN_RESET_N,
    output SEQ_DONE,
    output SEQ_FAULT,
    output FAULT_IDX,
    output RETRY_CNT
  );

  modport slave (
    output DOMAIN_READY,
    input  DOMAIN_RESET_N,
    input  SEQ_DONE,
    input  SEQ_FAULT,
    input  FAULT_IDX,
    input  RETRY_CNT
  );
endinterface

// File: rtl/reset_sequencer_pf.sv
// Releases NUM_DOMAINS fabric reset domains in index order, each after its predecessor acks plus a gap.
// Latency: domain 0 releases SYNC_STAGES+1+GAP_CYCLES edges after FABRIC_RESET_N is sampled high; later domains the same after the previous ack.
// Backpressure: none; a domain that never acks stalls the sequence (or times out with RESET_SEQ_ACK_TIMEOUT_EN).
//
// Ports:
//   CLK             sequencer clock
//   INTERNAL_RST    asynchronous active-low reset, clears every flop
//   FABRIC_RESET_N  upstream active-low reset, asynchronous to CLK
//   bus (master)    DOMAIN_READY in; DOMAIN_RESET_N, SEQ_DONE, SEQ_FAULT, FAULT_IDX, RETRY_CNT out
//
// Optional feature macro: RESET_SEQ_ACK_TIMEOUT_EN adds a per-domain ack timeout with bounded
// auto-retry; without it SEQ_FAULT, FAULT_IDX and RETRY_CNT are tied to 0.
module reset_sequencer_pf #(
  parameter int NUM_DOMAINS    = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                 CLK,
  input  logic                 INTERNAL_RST,
  input  logic                 FABRIC_RESET_N,
  reset_sequencer_pf_if.master bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GAP   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  localparam int         GW       = $clog2(GAP_CYCLES) + 1;
  localparam logic [2:0] IDX_LAST = 3'(NUM_DOMAINS - 1);

  // Elaboration-time parameter range checks.
  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8) begin : g_bad_num_domains
    $error("reset_sequencer_pf: NUM_DOMAINS must be 1..8");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("reset_sequencer_pf: GAP_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("reset_sequencer_pf: SYNC_STAGES must be >= 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("reset_sequencer_pf: TIMEOUT_CYCLES must be >= 2");
  end
  if (MAX_RETRIES < 0 || MAX_RETRIES > 7) begin : g_bad_retries
    $error("reset_sequencer_pf: MAX_RETRIES must be 0..7");
  end

  logic                   arst_fab_n;
  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic                   rst_sync;
  logic [NUM_DOMAINS-1:0] dom_q;
  logic [NUM_DOMAINS-1:0] dom_rst_n;
  logic [NUM_DOMAINS-1:0] ready_s;
  logic [NUM_DOMAINS-1:0] idx_oh;
  logic                   ready_sel;
  logic [2:0]             state;
  logic [2:0]             idx;
  logic [GW-1:0]          gap_cnt;

  // Upstream reset: asserts asynchronously (either reset source clears the chain), releases
  // synchronously. A glitch on FABRIC_RESET_N shorter than a clock still empties the chain.
  assign arst_fab_n = INTERNAL_RST & FABRIC_RESET_N;

  always_ff @(posedge CLK or negedge arst_fab_n) begin
    if (!arst_fab_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync  = rst_sync_q[SYNC_STAGES-1];
  assign dom_rst_n = dom_q & {NUM_DOMAINS{rst_sync}};

  // Ready synchronizers are held empty while their domain is in reset, so an ack that is
  // already high at release still pays the full pipeline delay and a stale ack from an
  // earlier attempt can never be seen.
  for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_rdy
    logic [SYNC_STAGES-1:0] q;

    always_ff @(posedge CLK or negedge INTERNAL_RST) begin
      if (!INTERNAL_RST) begin
        q <= '0;
      end else if (!dom_rst_n[i]) begin
        q <= '0;
      end else begin
        q <= {q[SYNC_STAGES-2:0], bus.DOMAIN_READY[i]};
      end
    end

    assign ready_s[i] = q[SYNC_STAGES-1];
  end

  always_comb begin
    idx_oh = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      idx_oh[i] = (3'(i) == idx);
    end
  end

  assign ready_sel = |(ready_s & idx_oh);

`ifdef RESET_SEQ_ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] to_cnt;
  logic [2:0]    retry_q;
  logic [2:0]    fidx_q;
`endif

  always_ff @(posedge CLK or negedge INTERNAL_RST) begin
    if (!INTERNAL_RST) begin
      state   <= ST_IDLE;
      idx     <= '0;
      dom_q   <= '0;
      gap_cnt <= '0;
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
      to_cnt  <= '0;
      retry_q <= '0;
      fidx_q  <= '0;
`endif
    end else if (!rst_sync) begin
      // Upstream reset is a full restart: fault and retry history go too.
      state   <= ST_IDLE;
      idx     <= '0;
      dom_q   <= '0;
      gap_cnt <= '0;
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
      to_cnt  <= '0;
      retry_q <= '0;
      fidx_q  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          dom_q   <= '0;
          gap_cnt <= '0;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            dom_q <= dom_q | idx_oh;
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
            to_cnt <= '0;
`endif
            state <= ST_WAIT;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        ST_WAIT: begin
          // Ready is tested first so it wins over a coincident timeout.
          if (ready_sel) begin
            if (idx == IDX_LAST) begin
              state <= ST_DONE;
            end else begin
              idx     <= idx + 3'd1;
              gap_cnt <= '0;
              state   <= ST_GAP;
            end
          end
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
          else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            fidx_q <= idx;
            dom_q  <= '0;
            if (retry_q < 3'(MAX_RETRIES)) begin
              retry_q <= retry_q + 3'd1;
              idx     <= '0;
              gap_cnt <= '0;
              state   <= ST_GAP;
            end else begin
              state <= ST_FAULT;
            end
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
`endif
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        ST_FAULT: begin
          // Only an upstream or internal reset leaves this state.
          dom_q <= '0;
          state <= ST_FAULT;
        end
        default: begin
          dom_q <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.DOMAIN_RESET_N = dom_rst_n;
  assign bus.SEQ_DONE       = (state == ST_DONE);

`ifdef RESET_SEQ_ACK_TIMEOUT_EN
  assign bus.SEQ_FAULT = (state == ST_FAULT);
  assign bus.FAULT_IDX = fidx_q;
  assign bus.RETRY_CNT = retry_q;
`else
  assign bus.SEQ_FAULT = 1'b0;
  assign bus.FAULT_IDX = 3'd0;
  assign bus.RETRY_CNT = 3'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer_pf.sv
// Bench for reset_sequencer_pf: randomized ack timing against a timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_reset_sequencer_pf;

  localparam int ND          = 4;
  localparam int G           = 16;
  localparam int S           = 2;
  localparam int T           = 64;
  localparam int MR          = 3;
  localparam int FIRST_REL   = S + 1 + G;
  localparam int HORIZON     = 1024;
  localparam int STUCK_LIMIT = 600;
  localparam int TIED        = -1000000;
  localparam int NEVER       = 1000000;
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic INTERNAL_RST;
  logic FABRIC_RESET_N;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  reset_sequencer_pf_if #(.NUM_DOMAINS(ND)) bus ();

  reset_sequencer_pf #(
    .NUM_DOMAINS   (ND),
    .GAP_CYCLES    (G),
    .SYNC_STAGES   (S),
    .TIMEOUT_CYCLES(T),
    .MAX_RETRIES   (MR)
  ) dut (
    .CLK           (CLK),
    .INTERNAL_RST  (INTERNAL_RST),
    .FABRIC_RESET_N(FABRIC_RESET_N),
    .bus           (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Expected outputs after edge k of the current run (k=0 is the edge before the upstream release).
  logic [ND-1:0] x_dom   [HORIZON];
  logic          x_done  [HORIZON];
  logic          x_fault [HORIZON];
  int            x_retry [HORIZON];
  int            x_fidx  [HORIZON];
  int            rr        [ND];  // edge after which DOMAIN_READY[i] is driven high
  int            ack_first [ND];
  int            end_k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Timeline model: a domain's ack is seen S+1 edges after the later of its release and its
  // ready rise; the next release follows G edges after that ack; the first release follows
  // G edges after the sequence starts at edge S+1. A timeout fires T edges after a release.
  task automatic build_plan();
    int g_e, rel, ack, t, retry;
    bit fin, first;
    for (int k = 0; k < HORIZON; k++) begin
      x_dom[k] = '0; x_done[k] = 1'b0; x_fault[k] = 1'b0; x_retry[k] = 0; x_fidx[k] = 0;
    end
    for (int i = 0; i < ND; i++) ack_first[i] = NEVER;
    g_e = S + 1; retry = 0; fin = 1'b0; first = 1'b1; end_k = STUCK_LIMIT;
    while (!fin) begin
      rel = g_e + G;
      for (int i = 0; i < ND; i++) begin
        ack = ((rel > rr[i]) ? rel : rr[i]) + S + 1;
        for (int k = rel; k < HORIZON; k++) x_dom[k][i] = 1'b1;
        if (TO_EN && ack > rel + T) begin
          t = rel + T;
          for (int k = t; k < HORIZON; k++) begin x_dom[k] = '0; x_fidx[k] = i; end
          if (retry < MR) begin
            retry++;
            for (int k = t; k < HORIZON; k++) x_retry[k] = retry;
            g_e = t;
          end else begin
            for (int k = t; k < HORIZON; k++) x_fault[k] = 1'b1;
            end_k = t + 8;
            fin = 1'b1;
          end
          break;
        end
        if (first) ack_first[i] = ack;
        if (i == ND - 1) begin
          for (int k = ack; k < HORIZON; k++) x_done[k] = 1'b1;
          end_k = ack + 8;
          fin = 1'b1;
        end else begin
          rel = ack + G;
        end
      end
      first = 1'b0;
    end
    if (end_k > STUCK_LIMIT) end_k = STUCK_LIMIT;
  endtask

  task automatic drive_ready(input int k);
    for (int i = 0; i < ND; i++) bus.DOMAIN_READY[i] = (k >= rr[i]);
  endtask

  task automatic check_all(input int k);
    chk("domain_reset_n", 32'(bus.DOMAIN_RESET_N), 32'(x_dom[k]));
    chk("seq_done",       32'(bus.SEQ_DONE),       32'(x_done[k]));
    chk("seq_fault",      32'(bus.SEQ_FAULT),      32'(x_fault[k]));
    chk("retry_cnt",      32'(bus.RETRY_CNT),      x_retry[k]);
    chk("fault_idx",      32'(bus.FAULT_IDX),      x_fidx[k]);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_domain_reset_n"}, 32'(bus.DOMAIN_RESET_N), 32'd0);
    chk({pfx, "_seq_done"},       32'(bus.SEQ_DONE),       32'd0);
    chk({pfx, "_seq_fault"},      32'(bus.SEQ_FAULT),      32'd0);
    chk({pfx, "_retry_cnt"},      32'(bus.RETRY_CNT),      32'd0);
    chk({pfx, "_fault_idx"},      32'(bus.FAULT_IDX),      32'd0);
  endtask

  // Called just after a sample point; leaves FABRIC_RESET_N high with the next edge as k=1.
  task automatic restart(input bit glitch);
    #1 FABRIC_RESET_N = 1'b0;
    #1 chk("async_domain_clear", 32'(bus.DOMAIN_RESET_N), 32'd0);
    if (glitch) begin
      FABRIC_RESET_N = 1'b1;
    end else begin
      @(posedge CLK); #1;
      check_zero("upstream_rst");
      FABRIC_RESET_N = 1'b1;
    end
  endtask

  task automatic run_plan(input int abort_k);
    for (int k = 1; k <= end_k; k++) begin
      @(posedge CLK); #1;
      check_all(k);
      drive_ready(k);
      if (k == abort_k) break;
    end
  endtask

  task automatic set_rr_all(input int v);
    for (int i = 0; i < ND; i++) rr[i] = v;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pending_irst;
    int abort_k;
    INTERNAL_RST     = 1'b0;
    FABRIC_RESET_N   = 1'b0;
    bus.DOMAIN_READY = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_zero("reset");

    // All acks tied high from power-up.
    set_rr_all(TIED);
    build_plan();
    INTERNAL_RST   = 1'b1;
    FABRIC_RESET_N = 1'b1;
    drive_ready(0);
    run_plan(-1);

    // Upstream reset out of DONE, then the same timing replayed.
    set_rr_all(TIED);
    build_plan();
    restart(1'b0);
    drive_ready(0);
    run_plan(-1);

    // Domain 2 acks late.
    set_rr_all(TIED);
    rr[2] = 150;
    build_plan();
    restart(1'b1);
    drive_ready(0);
    run_plan(-1);

    // Domain 1 never acks.
    set_rr_all(TIED);
    rr[1] = NEVER;
    build_plan();
    restart(1'b0);
    drive_ready(0);
    run_plan(-1);

    // Domain 0 ack seen exactly on the timeout edge, then one edge too late.
    set_rr_all(TIED);
    rr[0] = FIRST_REL + T - S - 1;
    build_plan();
    restart(1'b1);
    drive_ready(0);
    run_plan(-1);

    set_rr_all(TIED);
    rr[0] = FIRST_REL + T - S;
    build_plan();
    restart(1'b0);
    drive_ready(0);
    run_plan(-1);

    // Randomized ack timing; some runs are cut by INTERNAL_RST in the gap before domain 2.
    pending_irst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < ND; i++) rr[i] = int'($urandom_range(0, 24)) - 4;
      build_plan();
      if (pending_irst) begin
        INTERNAL_RST = 1'b1;
        pending_irst = 1'b0;
      end else begin
        restart(1'($urandom_range(0, 1)));
      end
      drive_ready(0);
      abort_k = (j % 3 == 1) ? ack_first[1] + G / 2 : -1;
      run_plan(abort_k);
      if (abort_k >= 0) begin
        #1 INTERNAL_RST = 1'b0;
        #1 check_zero("internal_rst");
        pending_irst = 1'b1;
      end
    end
    if (pending_irst) INTERNAL_RST = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
